ips2l_pcie_apb_arb_v1_0: RTL

Two-requester APB master arbiter/sequencer that shares the single debug APB bus (the one feeding the HSST/PCIe APB mux) between requester 0 (UART debug bridge) and requester 1 (on-chip config sequencer). It grants requesters round-robin and runs the SETUP/ACCESS APB sequence. Addresses the downstream mux cannot route are failed locally, and hung accesses are bounded by a timeout. It sits entirely in the UART clock domain, upstream of the mux.

---
 rtl/ips2l_pcie_apb_pkg.sv | 28 ++
 rtl/ips2l_pcie_apb_arb_v1_0_if.sv | 23 ++
 rtl/ips2l_pcie_apb_rr_arb_v1_0.sv | 52 +++++
 rtl/ips2l_pcie_apb_arb_v1_0.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ips2l_pcie_apb_pkg.sv
// ---------------------------------------------------------------------------
// ips2l_pcie_apb_pkg
// Shared definitions for the debug APB arbiter/sequencer: FSM state encoding,
// the address-decode constants describing what the downstream HSST/PCIe APB
// mux can route, and the read-data value returned on a failed access.
// ---------------------------------------------------------------------------
package ips2l_pcie_apb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } apbState_t;

   // Pages below this nibble belong to the HSST lanes
   localparam logic [3:0]  HSST_LIMIT = 4'h6;
   // The single page above the HSST range that the PCIe core decodes
   localparam logic [3:0]  PCIE_PAGE  = 4'h7;
   // Read data reported with a decode failure or a timeout
   localparam logic [31:0] ERR_RDATA  = 32'h0;

   // True when the mux downstream has somewhere to send this address
   function automatic logic isRoutable(input logic [15:0] addr);
      return (addr[15:12] < HSST_LIMIT) || (addr[15:12] == PCIE_PAGE);
   endfunction

endpackage

// File: rtl/ips2l_pcie_apb_arb_v1_0_if.sv
// ---------------------------------------------------------------------------
// ips2l_pcie_apb_arb_v1_0_if
// The shared debug APB bus between this arbiter (master) and the HSST/PCIe
// APB mux (slave).
//   sel, ce, we     : APB select / enable / write
//   strb, addr, wdata: APB payload
//   rdy, rdata      : slave ready and read data
// ---------------------------------------------------------------------------
interface ips2l_pcie_apb_arb_v1_0_if;

   logic        sel;
   logic        ce;
   logic        we;
   logic [3:0]  strb;
   logic [15:0] addr;
   logic [31:0] wdata;
   logic        rdy;
   logic [31:0] rdata;

   modport master (output sel, ce, we, strb, addr, wdata, input rdy, rdata);
   modport slave  (input sel, ce, we, strb, addr, wdata, output rdy, rdata);

endinterface

// File: rtl/ips2l_pcie_apb_rr_arb_v1_0.sv
// ---------------------------------------------------------------------------
// ips2l_pcie_apb_rr_arb_v1_0
// Two-way round-robin grant. A lone request wins immediately; on a tie the
// requester that was not granted last wins. The last-grant pointer starts at
// requester 1 so requester 0 takes the first tie.
//   i_clk, i_rst_n   : clock, async active-low reset
//   i_en             : grants only issued while high
//   i_req0, i_req1   : request levels
//   o_gnt0, o_gnt1   : one-hot (or zero) grant, combinational
// ---------------------------------------------------------------------------
module ips2l_pcie_apb_rr_arb_v1_0 (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_en,
   input  logic i_req0,
   input  logic i_req1,
   output logic o_gnt0,
   output logic o_gnt1
);

   logic r_lastM1;
   logic w_gnt0;
   logic w_gnt1;

   // Grant decision: on a tie the pointer picks whoever did not win last time.
   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (i_en) begin
         if (i_req0 && i_req1) begin
            w_gnt0 = r_lastM1;
            w_gnt1 = ~r_lastM1;
         end else begin
            w_gnt0 = i_req0;
            w_gnt1 = i_req1;
         end
      end
   end

   // The pointer follows every grant, including ones that later fail decode.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_lastM1 <= 1'b1;
      end else if (w_gnt0 || w_gnt1) begin
         r_lastM1 <= w_gnt1;
      end
   end

   assign o_gnt0 = w_gnt0;
   assign o_gnt1 = w_gnt1;

endmodule

// File: rtl/ips2l_pcie_apb_arb_v1_0.sv
// ---------------------------------------------------------------------------
// ips2l_pcie_apb_arb_v1_0
// Shares the debug APB bus between the UART debug bridge (m0) and the config
// sequencer (m1). Runs SETUP/ACCESS, fails unroutable addresses locally,
// bounds hung accesses with a TIMEOUT-cycle counter and keeps a saturating
// count of error completions.
//   i_clk, i_rst_n                 : UART clock, async active-low reset
//   i_mX_req/we/addr/wdata/strb    : requester X command, held until ack
//   o_mX_ack/err/rdata             : requester X one-cycle completion
//   apb                            : APB master side of the bus
//   o_busy                         : FSM not in IDLE
//   o_err_cnt                      : saturating error completion count
// ---------------------------------------------------------------------------
module ips2l_pcie_apb_arb_v1_0
   import ips2l_pcie_apb_pkg::*;
#(
   parameter int TIMEOUT = 1023
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_m0_req,
   input  logic        i_m0_we,
   input  logic [15:0] i_m0_addr,
   input  logic [31:0] i_m0_wdata,
   input  logic [3:0]  i_m0_strb,
   input  logic        i_m1_req,
   input  logic        i_m1_we,
   input  logic [15:0] i_m1_addr,
   input  logic [31:0] i_m1_wdata,
   input  logic [3:0]  i_m1_strb,
   output logic        o_m0_ack,
   output logic        o_m0_err,
   output logic [31:0] o_m0_rdata,
   output logic        o_m1_ack,
   output logic        o_m1_err,
   output logic [31:0] o_m1_rdata,
   ips2l_pcie_apb_arb_v1_0_if.master apb,
   output logic        o_busy,
   output logic [7:0]  o_err_cnt
);

   localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

   apbState_t   r_state;
   logic        r_gntM1;
   logic        r_pSel;
   logic        r_pCe;
   logic        r_pWe;
   logic [3:0]  r_pStrb;
   logic [15:0] r_pAddr;
   logic [31:0] r_pWdata;
   logic [15:0] r_tCnt;
   logic [7:0]  r_errCnt;
   logic        r_busy;
   logic        r_m0Ack;
   logic        r_m0Err;
   logic [31:0] r_m0Rdata;
   logic        r_m1Ack;
   logic        r_m1Err;
   logic [31:0] r_m1Rdata;

   logic        w_gnt0;
   logic        w_gnt1;
   logic        w_reqWe;
   logic [3:0]  w_reqStrb;
   logic [15:0] w_reqAddr;
   logic [31:0] w_reqWdata;
   logic        w_done;
   logic        w_doneM1;
   logic        w_doneErr;
   logic [31:0] w_doneRdata;

   // Grants are only offered while the bus is idle.
   ips2l_pcie_apb_rr_arb_v1_0 u_rrArb (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_en   (r_state == ST_IDLE),
      .i_req0 (i_m0_req),
      .i_req1 (i_m1_req),
      .o_gnt0 (w_gnt0),
      .o_gnt1 (w_gnt1)
   );

   // Command of whichever requester is being granted this cycle.
   always_comb begin
      w_reqWe    = w_gnt1 ? i_m1_we    : i_m0_we;
      w_reqStrb  = w_gnt1 ? i_m1_strb  : i_m0_strb;
      w_reqAddr  = w_gnt1 ? i_m1_addr  : i_m0_addr;
      w_reqWdata = w_gnt1 ? i_m1_wdata : i_m0_wdata;
   end

   // Completion detection: a decode fail completes straight from IDLE, an
   // access completes on rdy, or on timeout if rdy never came. rdy is checked
   // first so a response in the last allowed cycle still counts as success.
   always_comb begin
      w_done      = 1'b0;
      w_doneErr   = 1'b0;
      w_doneRdata = ERR_RDATA;
      w_doneM1    = r_gntM1;
      case (r_state)
         ST_IDLE: begin
            w_doneM1 = w_gnt1;
            if ((w_gnt0 || w_gnt1) && !isRoutable(w_reqAddr)) begin
               w_done    = 1'b1;
               w_doneErr = 1'b1;
            end
         end
         ST_ACCESS: begin
            if (apb.rdy) begin
               w_done      = 1'b1;
               w_doneRdata = r_pWe ? 32'h0 : apb.rdata;
            end else if (r_tCnt == TIMEOUT_CNT) begin
               w_done    = 1'b1;
               w_doneErr = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   // Main sequencer. Every output is a register, so each value is set on the
   // edge that enters the state in which it must be visible: bus controls on
   // entry to SETUP/ACCESS, ack/err/rdata and the error count on entry to RESP.
   // The ack registers default to zero every cycle so they pulse for RESP only.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= ST_IDLE;
         r_gntM1   <= 1'b0;
         r_pSel    <= 1'b0;
         r_pCe     <= 1'b0;
         r_pWe     <= 1'b0;
         r_pStrb   <= '0;
         r_pAddr   <= '0;
         r_pWdata  <= '0;
         r_tCnt    <= '0;
         r_errCnt  <= '0;
         r_busy    <= 1'b0;
         r_m0Ack   <= 1'b0;
         r_m0Err   <= 1'b0;
         r_m0Rdata <= '0;
         r_m1Ack   <= 1'b0;
         r_m1Err   <= 1'b0;
         r_m1Rdata <= '0;
      end else begin
         r_m0Ack   <= 1'b0;
         r_m0Err   <= 1'b0;
         r_m0Rdata <= '0;
         r_m1Ack   <= 1'b0;
         r_m1Err   <= 1'b0;
         r_m1Rdata <= '0;

         if (w_done) begin
            if (w_doneM1) begin
               r_m1Ack   <= 1'b1;
               r_m1Err   <= w_doneErr;
               r_m1Rdata <= w_doneRdata;
            end else begin
               r_m0Ack   <= 1'b1;
               r_m0Err   <= w_doneErr;
               r_m0Rdata <= w_doneRdata;
            end
            if (w_doneErr && (r_errCnt != 8'hFF)) begin
               r_errCnt <= r_errCnt + 8'd1;
            end
         end

         case (r_state)
            ST_IDLE: begin
               if (w_gnt0 || w_gnt1) begin
                  r_gntM1 <= w_gnt1;
                  r_busy  <= 1'b1;
                  if (w_done) begin
                     r_state <= ST_RESP;
                  end else begin
                     r_state  <= ST_SETUP;
                     r_pSel   <= 1'b1;
                     r_pWe    <= w_reqWe;
                     r_pStrb  <= w_reqStrb;
                     r_pAddr  <= w_reqAddr;
                     r_pWdata <= w_reqWdata;
                  end
               end
            end
            ST_SETUP: begin
               r_state <= ST_ACCESS;
               r_pCe   <= 1'b1;
               r_tCnt  <= 16'd1;
            end
            ST_ACCESS: begin
               if (w_done) begin
                  r_state  <= ST_RESP;
                  r_pSel   <= 1'b0;
                  r_pCe    <= 1'b0;
                  r_pWe    <= 1'b0;
                  r_pStrb  <= '0;
                  r_pAddr  <= '0;
                  r_pWdata <= '0;
               end else begin
                  r_tCnt <= r_tCnt + 16'd1;
               end
            end
            ST_RESP: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign apb.sel    = r_pSel;
   assign apb.ce     = r_pCe;
   assign apb.we     = r_pWe;
   assign apb.strb   = r_pStrb;
   assign apb.addr   = r_pAddr;
   assign apb.wdata  = r_pWdata;
   assign o_m0_ack   = r_m0Ack;
   assign o_m0_err   = r_m0Err;
   assign o_m0_rdata = r_m0Rdata;
   assign o_m1_ack   = r_m1Ack;
   assign o_m1_err   = r_m1Err;
   assign o_m1_rdata = r_m1Rdata;
   assign o_busy     = r_busy;
   assign o_err_cnt  = r_errCnt;

endmodule
